cacheline_adapter: RTL and testbench

- Memory-side responder for the 256-bit cache-line request interface used by the instruction-side prefetcher and the caches.
- Accepts held line read/write requests on the upstream port and serves them from a 64-bit burst memory port.
- A read issues one burst command and gathers BURST_LEN returned beats into a line.
- A write drives BURST_LEN consecutive write beats.
- One transaction is in flight at a time.

---
 rtl/cacheline_adapter_if.sv | 42 ++++
 rtl/cacheline_adapter.sv | 158 +++++++++++++++
 tb/tb_cacheline_adapter.sv | 270 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/cacheline_adapter_if.sv
`default_nettype none
// ============================================================================
// Module  : cacheline_adapter_if
// Brief   : Line request port plus burst memory port of the cache-line adapter.
// Revision: 1.0
// ============================================================================
interface cacheline_adapter_if #(
  parameter int BEAT_W = 64,
  parameter int LINE_W = 256
);
  logic [31:0]       ufp_addr;
  logic              ufp_read;
  logic              ufp_write;
  logic [LINE_W-1:0] ufp_wdata;
  logic [LINE_W-1:0] ufp_rdata;
  logic              ufp_resp;

  logic [31:0]       bmem_addr;
  logic              bmem_read;
  logic              bmem_write;
  logic [BEAT_W-1:0] bmem_wdata;
  logic              bmem_ready;
  logic [31:0]       bmem_raddr;
  logic [BEAT_W-1:0] bmem_rdata;
  logic              bmem_rvalid;

  // The adapter sits in the middle: slave on line requests, master on bursts.
  modport slave (
    input  ufp_addr, ufp_read, ufp_write, ufp_wdata,
    output ufp_rdata, ufp_resp,
    output bmem_addr, bmem_read, bmem_write, bmem_wdata,
    input  bmem_ready, bmem_raddr, bmem_rdata, bmem_rvalid
  );

  modport master (
    output ufp_addr, ufp_read, ufp_write, ufp_wdata,
    input  ufp_rdata, ufp_resp,
    input  bmem_addr, bmem_read, bmem_write, bmem_wdata,
    output bmem_ready, bmem_raddr, bmem_rdata, bmem_rvalid
  );
endinterface
`default_nettype wire

// File: rtl/cacheline_adapter.sv
`default_nettype none
// ============================================================================
// Module  : cacheline_adapter
// Brief   : Serves 256-bit line read/write requests from a 64-bit burst memory.
// Revision: 1.0
// ============================================================================
module cacheline_adapter #(
  parameter int BEAT_W    = 64,
  parameter int BURST_LEN = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  cacheline_adapter_if.slave  bus
);

  localparam int CNT_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam logic [CNT_W-1:0] c_last_beat = CNT_W'(BURST_LEN - 1);
  localparam logic [CNT_W-1:0] c_cnt_one   = CNT_W'(1);

  localparam logic [1:0] c_idle     = 2'd0;
  localparam logic [1:0] c_rd_wait  = 2'd1;
  localparam logic [1:0] c_wr_burst = 2'd2;
  localparam logic [1:0] c_done     = 2'd3;

  logic [1:0]                          r_state;
  logic [1:0]                          w_state_next;
  logic [CNT_W-1:0]                    r_cnt;
  logic [31:0]                         r_addr;
  logic [BURST_LEN-1:0][BEAT_W-1:0]    r_line;
  logic [BURST_LEN-1:0][BEAT_W-1:0]    r_rdata;
  logic [BURST_LEN-1:0][BEAT_W-1:0]    w_line_asm;

  logic [31:0] w_req_addr;
  logic        w_last;
  logic        w_beat_hit;
  logic        w_wr_accept;
  logic        w_cmd_accept;
  logic        w_unused_bits;

  assign w_req_addr    = {bus.ufp_addr[31:5], 5'b0};
  assign w_unused_bits = ^bus.ufp_addr[4:0];

  assign w_last       = (r_cnt == c_last_beat);
  // Only beats tagged with the latched line address belong to this burst.
  assign w_beat_hit   = (r_state == c_rd_wait) && bus.bmem_rvalid && (bus.bmem_raddr == r_addr);
  assign w_wr_accept  = (r_state == c_wr_burst) && bus.bmem_ready;
  assign w_cmd_accept = (r_state == c_idle) && !bus.ufp_write && bus.ufp_read && bus.bmem_ready;

  always_comb begin
    w_line_asm        = r_line;
    w_line_asm[r_cnt] = bus.bmem_rdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= c_idle;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      c_idle: begin
        if (bus.ufp_write) begin
          w_state_next = c_wr_burst;
        end else if (w_cmd_accept) begin
          w_state_next = c_rd_wait;
        end
      end
      c_rd_wait: begin
        if (w_beat_hit && w_last) begin
          w_state_next = c_done;
        end
      end
      c_wr_burst: begin
        if (w_wr_accept && w_last) begin
          w_state_next = c_done;
        end
      end
      c_done:  w_state_next = c_idle;
      default: w_state_next = c_idle;
    endcase
  end

  // Outputs are forced low while reset is held, even if a request is pending.
  always_comb begin
    bus.bmem_read  = 1'b0;
    bus.bmem_write = 1'b0;
    bus.bmem_addr  = 32'd0;
    bus.bmem_wdata = '0;
    bus.ufp_resp   = 1'b0;
    if (rst_n) begin
      case (r_state)
        c_idle: begin
          if (!bus.ufp_write && bus.ufp_read) begin
            bus.bmem_read = 1'b1;
            bus.bmem_addr = w_req_addr;
          end
        end
        c_rd_wait: begin
          bus.bmem_addr = r_addr;
        end
        c_wr_burst: begin
          bus.bmem_write = 1'b1;
          bus.bmem_addr  = r_addr;
          bus.bmem_wdata = r_line[r_cnt];
        end
        c_done: begin
          bus.ufp_resp = 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bus.ufp_rdata = r_rdata;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt   <= '0;
      r_addr  <= 32'd0;
      r_line  <= '0;
      r_rdata <= '0;
    end else begin
      case (r_state)
        c_idle: begin
          if (bus.ufp_write) begin
            r_addr <= w_req_addr;
            r_line <= bus.ufp_wdata;
            r_cnt  <= '0;
          end else if (w_cmd_accept) begin
            r_addr <= w_req_addr;
            r_cnt  <= '0;
          end
        end
        c_rd_wait: begin
          if (w_beat_hit) begin
            r_line <= w_line_asm;
            r_cnt  <= w_last ? '0 : r_cnt + c_cnt_one;
            if (w_last) begin
              r_rdata <= w_line_asm;
            end
          end
        end
        c_wr_burst: begin
          if (w_wr_accept) begin
            r_cnt <= w_last ? '0 : r_cnt + c_cnt_one;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_cacheline_adapter.sv
`default_nettype none
// ============================================================================
// Module  : tb_cacheline_adapter
// Brief   : Randomized self-checking bench for cacheline_adapter.
// Revision: 1.0
// ============================================================================
module tb_cacheline_adapter;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  cacheline_adapter_if #(.BEAT_W(64), .LINE_W(256)) bus ();

  cacheline_adapter #(.BEAT_W(64), .BURST_LEN(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  int checks = 0;
  int errors = 0;
  logic [63:0]  beat_q [4];
  logic [255:0] last_line;

  task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] rand64();
    return {$urandom, $urandom};
  endfunction

  function automatic logic [255:0] rand_line();
    logic [255:0] r;
    for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  // Read a line: command stall cycles, memory latency, optional stray beat
  // before beat stray_at, optional reset after abort_at beats.
  task automatic do_read(input logic [31:0] addr, input int cmd_stall, input int lat,
                         input int stray_at, input int abort_at);
    logic [31:0]  al;
    logic [255:0] line;
    al = {addr[31:5], 5'b0};
    for (int i = 0; i < 4; i++) line[i*64 +: 64] = beat_q[i];

    for (int k = 0; k <= cmd_stall; k++) begin
      @(negedge clk);
      bus.ufp_read    = 1'b1;
      bus.ufp_write   = 1'b0;
      bus.ufp_addr    = addr;
      bus.bmem_ready  = (k == cmd_stall);
      bus.bmem_rvalid = 1'b0;
      #1;
      chk("rd_cmd", bus.bmem_read, 1'b1);
      chk("rd_cmd_addr", bus.bmem_addr, al);
      chk("rd_cmd_noresp", bus.ufp_resp, 1'b0);
    end

    for (int k = 0; k < lat; k++) begin
      @(negedge clk);
      bus.ufp_addr    = $urandom;
      bus.bmem_ready  = 1'($urandom_range(0, 1));
      bus.bmem_rvalid = 1'b0;
      #1;
      chk("rd_nodup", bus.bmem_read, 1'b0);
      chk("rd_wait_noresp", bus.ufp_resp, 1'b0);
    end

    for (int i = 0; i < 4; i++) begin
      if (i == abort_at) begin
        @(negedge clk);
        rst_n           = 1'b0;
        bus.ufp_read    = 1'b0;
        bus.bmem_rvalid = 1'b0;
        #1;
        chk("rst_bmem_read", bus.bmem_read, 1'b0);
        chk("rst_bmem_write", bus.bmem_write, 1'b0);
        chk("rst_bmem_addr", bus.bmem_addr, 32'd0);
        chk("rst_bmem_wdata", bus.bmem_wdata, 64'd0);
        chk("rst_resp", bus.ufp_resp, 1'b0);
        chk("rst_rdata", bus.ufp_rdata, 256'd0);
        last_line = '0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int j = i; j < 4; j++) begin
          @(negedge clk);
          bus.bmem_rvalid = 1'b1;
          bus.bmem_raddr  = al;
          bus.bmem_rdata  = beat_q[j];
          #1;
          chk("post_rst_noresp", bus.ufp_resp, 1'b0);
          chk("post_rst_noread", bus.bmem_read, 1'b0);
        end
        @(negedge clk);
        bus.bmem_rvalid = 1'b0;
        #1;
        chk("post_rst_noresp_end", bus.ufp_resp, 1'b0);
        return;
      end
      if (i == stray_at) begin
        @(negedge clk);
        bus.ufp_addr    = $urandom;
        bus.bmem_rvalid = 1'b1;
        bus.bmem_raddr  = al ^ 32'h20;
        bus.bmem_rdata  = rand64();
        #1;
        chk("rd_stray_noresp", bus.ufp_resp, 1'b0);
      end
      @(negedge clk);
      bus.ufp_addr    = $urandom;
      bus.bmem_rvalid = 1'b1;
      bus.bmem_raddr  = al;
      bus.bmem_rdata  = beat_q[i];
      #1;
      chk("rd_beat_noresp", bus.ufp_resp, 1'b0);
      chk("rd_beat_nocmd", bus.bmem_read, 1'b0);
    end

    @(negedge clk);
    bus.ufp_read    = 1'b0;
    bus.bmem_rvalid = 1'($urandom_range(0, 1));
    bus.bmem_raddr  = al;
    bus.bmem_rdata  = rand64();
    #1;
    chk("rd_resp", bus.ufp_resp, 1'b1);
    chk("rd_line", bus.ufp_rdata, line);
    last_line = line;
  endtask

  // Write a line; either a fixed stall of stall_n cycles on beat stall_at,
  // or random ready. 'both' raises the read request as well.
  task automatic do_write(input logic [31:0] addr, input logic [255:0] wdata, input int stall_at,
                          input int stall_n, input bit rand_stall, input bit both);
    logic [31:0] al;
    int accepted;
    int stalls;
    int guard;
    logic rdy;
    al       = {addr[31:5], 5'b0};
    accepted = 0;
    stalls   = 0;
    guard    = 0;

    @(negedge clk);
    bus.ufp_write   = 1'b1;
    bus.ufp_read    = both;
    bus.ufp_addr    = addr;
    bus.ufp_wdata   = wdata;
    bus.bmem_ready  = 1'($urandom_range(0, 1));
    bus.bmem_rvalid = 1'b0;
    #1;
    chk("wr_idle_noread", bus.bmem_read, 1'b0);
    chk("wr_idle_nowrite", bus.bmem_write, 1'b0);
    chk("wr_idle_noresp", bus.ufp_resp, 1'b0);

    while (accepted < 4 && guard < 64) begin
      @(negedge clk);
      guard++;
      if (rand_stall) begin
        rdy = ($urandom_range(0, 2) != 0);
      end else if (accepted == stall_at && stalls < stall_n) begin
        rdy = 1'b0;
        stalls++;
      end else begin
        rdy = 1'b1;
      end
      bus.bmem_ready  = rdy;
      bus.ufp_addr    = $urandom;
      bus.ufp_wdata   = rand_line();
      bus.bmem_rvalid = 1'($urandom_range(0, 1));
      bus.bmem_raddr  = al;
      bus.bmem_rdata  = rand64();
      #1;
      chk("wr_strobe", bus.bmem_write, 1'b1);
      chk("wr_addr", bus.bmem_addr, al);
      chk("wr_data", bus.bmem_wdata, wdata[accepted*64 +: 64]);
      chk("wr_noread", bus.bmem_read, 1'b0);
      chk("wr_noresp", bus.ufp_resp, 1'b0);
      if (rdy) accepted++;
    end
    chk("wr_beats_accepted", accepted, 4);

    @(negedge clk);
    bus.ufp_write   = 1'b0;
    bus.ufp_read    = 1'b0;
    bus.bmem_ready  = 1'b1;
    bus.bmem_rvalid = 1'b0;
    #1;
    chk("wr_resp", bus.ufp_resp, 1'b1);
    chk("wr_done_nowrite", bus.bmem_write, 1'b0);
    chk("wr_rdata_held", bus.ufp_rdata, last_line);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    logic [255:0] wline;
    rst_n           = 1'b0;
    bus.ufp_read    = 1'b1;
    bus.ufp_write   = 1'b0;
    bus.ufp_addr    = 32'h1234_5678;
    bus.ufp_wdata   = '0;
    bus.bmem_ready  = 1'b1;
    bus.bmem_rvalid = 1'b0;
    bus.bmem_raddr  = '0;
    bus.bmem_rdata  = '0;
    last_line       = '0;

    @(negedge clk);
    #1;
    chk("reset_bmem_read", bus.bmem_read, 1'b0);
    chk("reset_bmem_addr", bus.bmem_addr, 32'd0);
    chk("reset_bmem_write", bus.bmem_write, 1'b0);
    chk("reset_bmem_wdata", bus.bmem_wdata, 64'd0);
    chk("reset_resp", bus.ufp_resp, 1'b0);
    chk("reset_rdata", bus.ufp_rdata, 256'd0);
    bus.ufp_read = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

    beat_q = '{64'h1111_1111_1111_1111, 64'h2222_2222_2222_2222,
               64'h3333_3333_3333_3333, 64'h4444_4444_4444_4444};
    do_read(32'h0000_1234, 0, 0, -1, -1);

    wline = rand_line();
    do_write(32'h0000_0040, wline, 1, 2, 1'b0, 1'b0);

    for (int i = 0; i < 4; i++) beat_q[i] = rand64();
    do_read(32'h0000_0300, 3, 2, -1, -1);

    for (int i = 0; i < 4; i++) beat_q[i] = rand64();
    do_read(32'h0000_0080, 0, 1, 2, -1);

    for (int i = 0; i < 4; i++) beat_q[i] = rand64();
    do_read(32'h0000_0100, 0, 0, -1, -1);
    for (int i = 0; i < 4; i++) beat_q[i] = rand64();
    do_read(32'h0000_0120, 0, 0, -1, -1);

    for (int i = 0; i < 4; i++) beat_q[i] = rand64();
    do_read(32'h0000_0180, 0, 0, -1, 2);
    for (int i = 0; i < 4; i++) beat_q[i] = rand64();
    do_read(32'h0000_0200, 0, 1, -1, -1);

    for (int n = 0; n < 30; n++) begin
      if ($urandom_range(0, 1) == 0) begin
        for (int i = 0; i < 4; i++) beat_q[i] = rand64();
        do_read($urandom, int'($urandom_range(0, 3)), int'($urandom_range(0, 4)),
                int'($urandom_range(0, 4)) - 1, -1);
      end else begin
        do_write($urandom, rand_line(), -1, 0, 1'b1, 1'($urandom_range(0, 1)));
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
